i2s_tdm_tx: RTL

Parametrised audio serial transmitter. It generalises the fixed stereo I2S output to N channels, any sample width and three framing modes: I2S, left-justified and TDM.
It sits between the core's audio mixer and the I2S_BCK/I2S_LRCK/I2S_DATA pins. The same outputs can feed the HDMI transmitter's I2S input.
A one-frame holding buffer with a valid/ready handshake decouples the mixer's sample rate from the serial frame rate. On underrun the block repeats the last frame.

---
 rtl/i2s_tdm_tx_pkg.sv | 13 +
 rtl/i2s_tdm_tx_if.sv | 23 ++
 rtl/i2s_tdm_tx_bck_gen.sv | 38 +++
 rtl/i2s_tdm_tx.sv | 122 ++++++++++++
 4 files changed

// File: rtl/i2s_tdm_tx_pkg.sv
// Shared audio serial definitions: framing modes
// and the position-width helper.
package audio_pkg;

  localparam int AUDIO_MODE_I2S = 0;
  localparam int AUDIO_MODE_LJ  = 1;
  localparam int AUDIO_MODE_TDM = 2;

  function automatic int pos_width(input int frame);
    return (frame > 1) ? $clog2(frame) : 1;
  endfunction

endpackage

// File: rtl/i2s_tdm_tx_if.sv
// Frame handshake between the audio mixer
// and the serial transmitter.
interface i2s_tdm_tx_if #(
  parameter int W = 32
) ();

  logic [W-1:0] sample_in;
  logic         sample_valid;
  logic         sample_ready;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/i2s_tdm_tx_bck_gen.sv
// Bit clock divider: toggles bck every BCK_DIV
// cycles and flags the cycle of each toggle.
module i2s_bck_gen
  import audio_pkg::*;
#(
  parameter int BCK_DIV = 4
) (
  input  logic clk_sys,
  input  logic reset,
  output logic bck,
  output logic fall_evt,
  output logic rise_evt
);

  localparam int CW = pos_width(BCK_DIV);

  logic [CW-1:0] div_cnt;
  logic          wrap;

  assign wrap     = (div_cnt == CW'(BCK_DIV - 1));
  // Strobes lead the edge they name by one
  // clk_sys cycle, so users update with bck.
  assign fall_evt = wrap & bck;
  assign rise_evt = wrap & ~bck;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_cnt <= '0;
      bck     <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bck     <= ~bck;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2s_tdm_tx.sv
// N-channel I2S / left-justified / TDM serialiser
// with a one-frame holding buffer.
module i2s_tdm_tx
  import audio_pkg::*;
#(
  parameter int AUDIO_DW = 16,
  parameter int CHANNELS = 2,
  parameter int SLOT_W   = 32,
  parameter int BCK_DIV  = 4,
  parameter int MODE     = AUDIO_MODE_I2S
) (
  input  logic        clk_sys,
  input  logic        reset,
  i2s_tdm_tx_if.slave aud,
  output logic        i2s_bck,
  output logic        i2s_lrck,
  output logic        i2s_data,
  output logic        underrun
);

  localparam int FRAME = CHANNELS * SLOT_W;
  localparam int PW    = pos_width(FRAME);
  localparam int SW    = CHANNELS * AUDIO_DW;
  localparam int IW    = pos_width(SW);
  localparam logic [PW-1:0] P_LAST = PW'(FRAME - 1);

  if (AUDIO_DW < 1 || AUDIO_DW > SLOT_W) begin : g_bad_dw
    $error("i2s_tdm_tx: AUDIO_DW must be 1..SLOT_W");
  end
  if (MODE < AUDIO_MODE_I2S || MODE > AUDIO_MODE_TDM)
  begin : g_bad_mode
    $error("i2s_tdm_tx: unknown MODE");
  end
  if ((MODE == AUDIO_MODE_TDM) ?
      (CHANNELS < 2 || CHANNELS > 16) :
      (CHANNELS != 2)) begin : g_bad_ch
    $error("i2s_tdm_tx: CHANNELS does not fit MODE");
  end
  if (BCK_DIV < 1) begin : g_bad_div
    $error("i2s_tdm_tx: BCK_DIV must be >= 1");
  end

  logic          fall_evt;
  logic          rise_evt;
  logic [PW-1:0] pos;
  logic [PW-1:0] p_nxt;
  logic [SW-1:0] frm_q;
  logic [SW-1:0] buf_q;
  logic [SW-1:0] frm_sel;
  logic          full_q;
  logic          dly_q;
  logic          load_evt;
  logic          take;
  logic          acc;
  int            slot_i;
  int            bit_i;
  logic [IW-1:0] idx;
  logic          bit_nxt;
  logic          lr_nxt;

  i2s_bck_gen #(
    .BCK_DIV (BCK_DIV)
  ) u_bck (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .bck      (i2s_bck),
    .fall_evt (fall_evt),
    .rise_evt (rise_evt)
  );

  assign p_nxt    = (pos == P_LAST) ? '0 : pos + PW'(1);
  assign load_evt = fall_evt && (p_nxt == '0);
  assign take     = load_evt && full_q;
  assign acc      = aud.sample_valid && !full_q;
  assign frm_sel  = take ? buf_q : frm_q;

  assign aud.sample_ready = !full_q;

  // Bit for the position being entered, taken
  // from the frame that will be live there.
  always_comb begin
    slot_i  = int'(p_nxt) / SLOT_W;
    bit_i   = int'(p_nxt) % SLOT_W;
    idx     = IW'(slot_i * AUDIO_DW + AUDIO_DW - 1 - bit_i);
    bit_nxt = 1'b0;
    if (bit_i < AUDIO_DW) bit_nxt = frm_sel[idx];
    if (MODE == AUDIO_MODE_TDM) lr_nxt = (p_nxt == '0);
    else                        lr_nxt = (slot_i == 1);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pos      <= P_LAST;
      frm_q    <= '0;
      buf_q    <= '0;
      full_q   <= 1'b0;
      dly_q    <= 1'b0;
      i2s_lrck <= 1'b0;
      i2s_data <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= load_evt && !full_q;
      if (acc) begin
        buf_q  <= aud.sample_in;
        full_q <= 1'b1;
      end
      if (take) begin
        frm_q  <= buf_q;
        full_q <= 1'b0;
      end
      if (fall_evt) begin
        pos      <= p_nxt;
        dly_q    <= bit_nxt;
        i2s_lrck <= lr_nxt;
        i2s_data <= (MODE == AUDIO_MODE_I2S) ?
                    dly_q : bit_nxt;
      end
      assert (!(fall_evt && rise_evt));
    end
  end

endmodule
